// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, issues one instruction-memory read at a time
// and holds the returned word in a one-entry IF/ID buffer for decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        decode_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out
);
    typedef enum logic [1:0] {FETCH, WAIT, DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, pc_out_q, pc_out_d;
    logic        valid_q, valid_d, go_q;
    logic        consume;

    assign consume     = valid_q && decode_ready;
    // go_q keeps the request low during reset and for the first cycle after it
    assign imem_req    = go_q && state_q == FETCH && !redirect_valid && (!valid_q || decode_ready);
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q && !consume;
        instr_d  = consume ? NOP_INSTR : instr_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            state_d = (state_q == FETCH || imem_rvalid) ? FETCH : DROP;
        end else begin
            case (state_q)
                FETCH: state_d = imem_req ? WAIT : FETCH;
                WAIT: begin
                    if (imem_rvalid) begin
                        valid_d  = 1'b1;
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = FETCH;
                    end
                end
                DROP:    state_d = imem_rvalid ? FETCH : DROP;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc_out_q <= RESET_PC;
            valid_q  <= 1'b0;
            go_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            go_q     <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vectors, corner sequences and random traffic
// against a transaction-level model of the fetch stage.
module tb_instruction_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req, imem_rvalid = 1'b0, redirect_valid = 1'b0, decode_ready = 1'b0, instr_valid;
    logic [31:0] imem_addr, imem_rdata = '0, redirect_pc = '0, instr, pc_out;
    logic        req2, rv2, valid2;
    logic [31:0] addr2, instr2, pc_out2;
    logic [31:0] a2 [2];
    int          n2;

    instruction_fetch dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .decode_ready(decode_ready), .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
        .imem_rdata(32'h0000_0013), .imem_rvalid(rv2),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .decode_ready(1'b1),
        .instr_valid(valid2), .instr(instr2), .pc_out(pc_out2)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rv2 <= 1'b0;
            n2  <= 0;
        end else begin
            rv2 <= req2;
            if (req2) begin
                if (n2 < 2) a2[n2] <= addr2;
                n2 <= n2 + 1;
            end
        end
    end

    typedef struct {int due; logic [31:0] addr;} rsp_t;
    typedef struct {
        logic rv; logic [31:0] rpc; logic dr;
        logic req; logic [31:0] addr; logic vld; logic [31:0] pco;
    } vec_t;

    rsp_t        q[$];
    int          n_chk = 0, n_fail = 0, cyc = 0, lat = 1;
    logic        m_go, m_wait, m_stale, m_valid;
    logic [31:0] m_pc, m_instr, m_pcout;
    logic        cur_rv, cur_dr, cur_rvalid, rsp_now, exp_req, seen_req, got;
    logic [31:0] cur_rpc, cur_rdata, seen_addr;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_go = 0; m_wait = 0; m_stale = 0; m_valid = 0;
        m_pc = 32'h0; m_pcout = 32'h0; m_instr = NOP;
    endtask

    task automatic do_reset(input logic clear_q);
        rst = 1'b1; imem_rvalid = 1'b0; redirect_valid = 1'b0;
        #1;
        check("rst_req", 32'(imem_req), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_instr", instr, NOP);
        check("rst_pcout", pc_out, 32'h0);
        model_reset();
        if (clear_q) q.delete();
        @(posedge clk); cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic dr, input logic spur);
        cur_rv = rv; cur_rpc = rpc; cur_dr = dr;
        rsp_now    = q.size() > 0 && q[0].due <= cyc;
        cur_rvalid = rsp_now || (spur && q.size() == 0 && !m_wait);
        cur_rdata  = rsp_now ? word(q[0].addr) : 32'($urandom);
        redirect_valid = rv; redirect_pc = rpc; decode_ready = dr;
        imem_rvalid = cur_rvalid; imem_rdata = cur_rdata;
        #1;
        exp_req = m_go && !m_wait && !rv && (!m_valid || dr);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("instr", instr, m_valid ? m_instr : NOP);
        if (m_valid) check("pc_out", pc_out, m_pcout);
        seen_req = imem_req; seen_addr = imem_addr;
    endtask

    // Model: the next fetch address, whether a request is in flight and whether
    // a redirect has made it stale, and the buffered word.
    task automatic commit();
        @(posedge clk);
        if (cur_rv) begin
            m_pc = {cur_rpc[31:2], 2'b00};
            m_valid = 0;
            if (m_wait) begin
                m_stale = !cur_rvalid;
                m_wait  = !cur_rvalid;
            end
        end else begin
            if (m_valid && cur_dr) m_valid = 0;
            if (m_wait && cur_rvalid) begin
                if (!m_stale) begin
                    m_valid = 1; m_instr = cur_rdata; m_pcout = m_pc; m_pc = m_pc + 32'd4;
                end
                m_wait = 0; m_stale = 0;
            end else if (exp_req) m_wait = 1;
        end
        m_go = 1;
        if (rsp_now) q.delete(0);
        if (seen_req) q.push_back('{cyc + lat, seen_addr});
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        vec_t tab [17];
        tab[0]  = '{0, 0, 1, 0, 0, 0, 0};
        tab[1]  = '{0, 0, 1, 1, 32'h0, 0, 0};
        tab[2]  = '{0, 0, 1, 0, 0, 0, 0};
        tab[3]  = '{0, 0, 0, 0, 0, 1, 32'h0};
        tab[4]  = '{0, 0, 0, 0, 0, 1, 32'h0};
        tab[5]  = '{0, 0, 0, 0, 0, 1, 32'h0};
        tab[6]  = '{0, 0, 0, 0, 0, 1, 32'h0};
        tab[7]  = '{0, 0, 0, 0, 0, 1, 32'h0};
        tab[8]  = '{0, 0, 1, 1, 32'h4, 1, 32'h0};
        tab[9]  = '{0, 0, 1, 0, 0, 0, 0};
        tab[10] = '{0, 0, 1, 1, 32'h8, 1, 32'h4};
        tab[11] = '{0, 0, 1, 0, 0, 0, 0};
        tab[12] = '{0, 0, 1, 1, 32'hC, 1, 32'h8};
        tab[13] = '{1, 32'h203, 1, 0, 0, 0, 0};
        tab[14] = '{0, 0, 1, 1, 32'h200, 0, 0};
        tab[15] = '{0, 0, 1, 0, 0, 0, 0};
        tab[16] = '{0, 0, 1, 1, 32'h204, 1, 32'h200};

        @(negedge clk);
        do_reset(1);
        lat = 1;
        foreach (tab[i]) begin
            drive(tab[i].rv, tab[i].rpc, tab[i].dr, 0);
            check($sformatf("t%0d_req", i), 32'(imem_req), 32'(tab[i].req));
            if (tab[i].req) check($sformatf("t%0d_addr", i), imem_addr, tab[i].addr);
            check($sformatf("t%0d_valid", i), 32'(instr_valid), 32'(tab[i].vld));
            if (tab[i].vld) begin
                check($sformatf("t%0d_pcout", i), pc_out, tab[i].pco);
                check($sformatf("t%0d_instr", i), instr, word(tab[i].pco));
            end
            commit();
        end

        // Redirect while the fetch of 0x8 is outstanding with 4-cycle latency
        do_reset(1);
        lat = 1; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            drive(0, 0, 1, 0);
            if (imem_req && imem_addr == 32'h8) begin lat = 4; got = 1; end
            commit();
        end
        check("rw_req8_seen", 32'(got), 1);
        drive(1, 32'h100, 1, 0);
        commit();
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            drive(0, 0, 1, 0);
            if (imem_req) begin check("rw_addr", imem_addr, 32'h100); got = 1; end
            else check("rw_drop_novalid", 32'(instr_valid), 0);
            commit();
        end
        check("rw_req_timeout", 32'(got), 1);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            drive(0, 0, 1, 0);
            if (instr_valid) begin check("rw_pcout", pc_out, 32'h100); got = 1; end
            commit();
        end
        check("rw_valid_timeout", 32'(got), 1);

        // Asynchronous reset while a 3-cycle fetch is in flight
        do_reset(1);
        lat = 3; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            drive(0, 0, 1, 0);
            got = imem_req;
            commit();
        end
        check("ar_req_seen", 32'(got), 1);
        drive(0, 0, 1, 0);
        #2 rst = 1'b1;
        #1;
        check("ar_req", 32'(imem_req), 0);
        check("ar_valid", 32'(instr_valid), 0);
        check("ar_instr", instr, NOP);
        check("ar_pcout", pc_out, 32'h0);
        model_reset();
        @(posedge clk); cyc++;
        @(negedge clk);
        rst = 1'b0;
        lat = 1; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            drive(0, 0, 1, 0);
            if (imem_req) begin check("ar_addr", imem_addr, 32'h0); got = 1; end
            commit();
        end
        check("ar_req_timeout", 32'(got), 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) == 0, 32'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0);
            lat = $urandom_range(1, 4);
            commit();
        end

        check("wrap_count", 32'(n2 >= 2), 1);
        check("wrap_first", a2[0], 32'hFFFF_FFFC);
        check("wrap_second", a2[1], 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
